// File: rtl/comp_pkg.sv
// Shared types and defaults for the 1-bit comparator.
// Result classes plus the default counter width.
package comp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_t;

  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/comp_1bit_core.sv
// Combinational 1-bit compare decode.
// Emits one-hot flags and the matching result class.
module comp_1bit_core
  import comp_pkg::*;
(
  input  logic     a,
  input  logic     b,
  output logic     gt,
  output logic     lt,
  output logic     eq,
  output cmp_res_t res
);

  always_comb begin
    gt  = 1'b0;
    lt  = 1'b0;
    eq  = 1'b0;
    res = CMP_EQ;
    unique case ({a, b})
      2'b00: eq = 1'b1;
      2'b01: begin
        lt  = 1'b1;
        res = CMP_LT;
      end
      2'b10: begin
        gt  = 1'b1;
        res = CMP_GT;
      end
      2'b11: eq = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/comp_1bit.sv
// Registered 1-bit magnitude comparator.
// Adds saturating per-class sample counters.
module comp_1bit
  import comp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  input  logic             clr,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_eq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic     d_gt;
  logic     d_lt;
  logic     d_eq;
  cmp_res_t d_res;

  comp_1bit_core u_core (
    .a   (a),
    .b   (b),
    .gt  (d_gt),
    .lt  (d_lt),
    .eq  (d_eq),
    .res (d_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      out_valid <= 1'b0;
      cnt_gt    <= '0;
      cnt_lt    <= '0;
      cnt_eq    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gt <= d_gt;
        lt <= d_lt;
        eq <= d_eq;
      end
      // clr wins over the sample arriving in the same cycle
      if (clr) begin
        cnt_gt <= '0;
        cnt_lt <= '0;
        cnt_eq <= '0;
      end else if (in_valid) begin
        unique case (d_res)
          CMP_GT:
            if (cnt_gt != CNT_MAX)
              cnt_gt <= cnt_gt + 1'b1;
          CMP_LT:
            if (cnt_lt != CNT_MAX)
              cnt_lt <= cnt_lt + 1'b1;
          default:
            if (cnt_eq != CNT_MAX)
              cnt_eq <= cnt_eq + 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comp_1bit.sv
// Bench for comp_1bit: abstract model plus directed vectors.
// Runs a default-width and a 2-bit-counter instance side by side.
module tb_comp_1bit;

  logic clk = 1'b0;
  logic rst, a, b, in_valid, clr;

  logic       gt8, lt8, eq8, ov8;
  logic [7:0] cg8, cl8, ce8;
  logic       gt2, lt2, eq2, ov2;
  logic [1:0] cg2, cl2, ce2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model state: flags and per-class counts (0=gt,1=lt,2=eq)
  int m_gt, m_lt, m_eq, m_ov;
  int m8 [3];
  int m2 [3];

  always #5 clk = ~clk;

  comp_1bit u_d8 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .in_valid(in_valid), .clr(clr),
    .gt(gt8), .lt(lt8), .eq(eq8),
    .out_valid(ov8),
    .cnt_gt(cg8), .cnt_lt(cl8), .cnt_eq(ce8)
  );

  comp_1bit #(.CNT_W(2)) u_d2 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .in_valid(in_valid), .clr(clr),
    .gt(gt2), .lt(lt2), .eq(eq2),
    .out_valid(ov2),
    .cnt_gt(cg2), .cnt_lt(cl2), .cnt_eq(ce2)
  );

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // model: magnitude compare done arithmetically
  always @(posedge clk) begin
    int cls;
    if (rst) begin
      m_gt = 0; m_lt = 0; m_eq = 0; m_ov = 0;
      for (int i = 0; i < 3; i++) begin
        m8[i] = 0;
        m2[i] = 0;
      end
    end else begin
      cls = (int'(a) > int'(b)) ? 0 :
            (int'(a) < int'(b)) ? 1 : 2;
      m_ov = int'(in_valid);
      if (in_valid) begin
        m_gt = (cls == 0);
        m_lt = (cls == 1);
        m_eq = (cls == 2);
      end
      for (int i = 0; i < 3; i++) begin
        if (clr) begin
          m8[i] = 0;
          m2[i] = 0;
        end else if (in_valid && i == cls) begin
          m8[i] = (m8[i] + 1 > 255) ? 255 : m8[i] + 1;
          m2[i] = (m2[i] + 1 > 3) ? 3 : m2[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gt8", gt8, m_gt);
      chk("lt8", lt8, m_lt);
      chk("eq8", eq8, m_eq);
      chk("ov8", ov8, m_ov);
      chk("cg8", cg8, m8[0]);
      chk("cl8", cl8, m8[1]);
      chk("ce8", ce8, m8[2]);
      chk("gt2", gt2, m_gt);
      chk("lt2", lt2, m_lt);
      chk("eq2", eq2, m_eq);
      chk("ov2", ov2, m_ov);
      chk("cg2", cg2, m2[0]);
      chk("cl2", cl2, m2[1]);
      chk("ce2", ce2, m2[2]);
      if (ov8)
        chk("onehot8", gt8 + lt8 + eq8, 1);
    end
  end

  task automatic step(bit r, bit c, bit v,
                      logic xa, logic xb);
    rst      = r;
    clr      = c;
    in_valid = v;
    a        = xa;
    b        = xb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    a = 1'b0; b = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_flags", {gt8, lt8, eq8}, 0);
    chk("rst_ov", ov8, 0);
    chk("rst_cnt", cg8 + cl8 + ce8, 0);

    // truth table
    step(0, 0, 1, 0, 0);
    chk("tt00_eq", {gt8, lt8, eq8}, 3'b001);
    step(0, 0, 1, 0, 1);
    chk("tt01_lt", {gt8, lt8, eq8}, 3'b010);
    step(0, 0, 1, 1, 0);
    chk("tt10_gt", {gt8, lt8, eq8}, 3'b100);
    step(0, 0, 1, 1, 1);
    chk("tt11_eq", {gt8, lt8, eq8}, 3'b001);
    chk("tt_ov", ov8, 1);
    chk("tt_ceq", ce8, 2);
    chk("tt_clt", cl8, 1);
    chk("tt_cgt", cg8, 1);

    // hold
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("hold_gt", gt8, 1);
    chk("hold_ov", ov8, 0);
    chk("hold_clt", cl8, 1);
    step(0, 0, 0, 1'bx, 1'bx);
    chk("x_gt", gt8, 1);

    // saturation of the 2-bit instance
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 1, 1);
    chk("sat2_ceq", ce2, 3);
    step(0, 0, 0, 0, 0);
    chk("sat2_hold", ce2, 3);
    chk("sat2_cgt", cg2, 2);

    // saturation of the 8-bit instance
    for (int i = 0; i < 260; i++)
      step(0, 0, 1, 0, 0);
    chk("sat8_ceq", ce8, 255);

    // clear collision
    step(0, 1, 1, 0, 1);
    chk("clr_cnt", cg8 + cl8 + ce8, 0);
    chk("clr_lt", lt8, 1);
    chk("clr_ov", ov8, 1);

    // a few mixed vectors
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("mix_clt", cl8, 2);
    chk("mix_cgt", cg8, 1);

    // mid-stream reset
    step(1, 0, 1, 1, 0);
    chk("mrst_gt", gt8, 0);
    chk("mrst_ov", ov8, 0);
    chk("mrst_cnt", cg8 + cl8 + ce8, 0);
    step(0, 0, 1, 1, 0);
    chk("post_gt", gt8, 1);
    step(0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
